// File: rtl/gray_conv_pkg.sv
// Shared types and constants for the shared Gray-code conversion arbiter.
package gray_conv_pkg;

  typedef enum logic {DIR_B2G = 1'b0, DIR_G2B = 1'b1} conv_dir_e;

  typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_state_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/gray_conv_arbiter_conv.sv
// Bitwise binary<->Gray converters shared by all requesters of gray_conv_arbiter.
module Binary2Gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ {1'b0, bin[WIDTH-1:1]};

endmodule

module Gray2Binary #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched cyclically from last_grant+1.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W-1:0]    last_grant_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    idx_s;
  logic               found_s;
  int                 cand_s;

  // Cyclic priority search starting just after the previous winner.
  always_comb begin
    grant_s = '0;
    idx_s   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s = (int'(last_grant_r) + k) % NUM_REQ;
      if (enable && !found_s && req[cand_s]) begin
        grant_s[cand_s] = 1'b1;
        idx_s           = ID_W'(cand_s);
        found_s         = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant     = grant_s;
  assign grant_idx = idx_s;

  // Pointer moves only on a grant; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= ID_W'(NUM_REQ - 1);
    end else if (found_s) begin
      last_grant_r <= idx_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one Binary2Gray/Gray2Binary pair among NUM_REQ requesters with a registered response slot.
// Optional stall statistics (stall_cnt/stall_clr) are enabled by defining GRAY_CONV_ARB_STATS_EN.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_dir,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id
`ifdef GRAY_CONV_ARB_STATS_EN
  ,
  input  logic                     stall_clr,
  output logic [STAT_W-1:0]        stall_cnt
`endif
);

  slot_state_e        state_r;
  logic               rsp_valid_r;
  logic [WIDTH-1:0]   rsp_data_r;
  logic [ID_W-1:0]    rsp_id_r;

  logic               slot_free_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic               any_grant_s;
  logic [WIDTH-1:0]   sel_data_s;
  conv_dir_e          sel_dir_s;
  logic [WIDTH-1:0]   b2g_s;
  logic [WIDTH-1:0]   g2b_s;
  logic [WIDTH-1:0]   conv_s;

  assign slot_free_s = !rsp_valid_r || rsp_ready;
  assign any_grant_s = |grant_s;
  assign req_ready   = grant_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (slot_free_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Steer the granted requester's operand and direction into the shared converters.
  always_comb begin
    sel_data_s = req_data[int'(grant_idx_s)*WIDTH +: WIDTH];
    sel_dir_s  = conv_dir_e'(req_dir[grant_idx_s]);
  end

  Binary2Gray #(.WIDTH(WIDTH)) u_b2g (.bin(sel_data_s), .gray(b2g_s));
  Gray2Binary #(.WIDTH(WIDTH)) u_g2b (.gray(sel_data_s), .bin(g2b_s));

  // Direction picks which converter result is loaded.
  always_comb begin
    conv_s = b2g_s;
    case (sel_dir_s)
      DIR_B2G: conv_s = b2g_s;
      DIR_G2B: conv_s = g2b_s;
      default: conv_s = b2g_s;
    endcase
  end

  // Response slot FSM; a grant while FULL implies rsp_ready, so drain and reload share the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SLOT_EMPTY;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_id_r    <= '0;
    end else begin
      case (state_r)
        SLOT_EMPTY: begin
          if (any_grant_s) begin
            state_r     <= SLOT_FULL;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= conv_s;
            rsp_id_r    <= grant_idx_s;
          end else begin
            state_r     <= SLOT_EMPTY;
            rsp_valid_r <= 1'b0;
          end
        end
        SLOT_FULL: begin
          if (any_grant_s) begin
            state_r     <= SLOT_FULL;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= conv_s;
            rsp_id_r    <= grant_idx_s;
          end else if (rsp_ready) begin
            state_r     <= SLOT_EMPTY;
            rsp_valid_r <= 1'b0;
          end else begin
            state_r     <= SLOT_FULL;
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= SLOT_EMPTY;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_id    = rsp_id_r;

`ifdef GRAY_CONV_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cnt_r;

  // Saturating stall counter; a clear in a stall cycle takes precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= '0;
    end else if (stall_clr) begin
      stall_cnt_r <= '0;
    end else if (rsp_valid_r && !rsp_ready && (stall_cnt_r != {STAT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Shares one Gray-code conversion resource (one Binary2Gray and one Gray2Binary instance) between NUM_REQ requesters. Each requester presents a value and a direction. The block arbitrates round-robin, converts the granted value, and returns the result in a registered response slot with valid/ready backpressure. It sits between requester logic (pointer/counter blocks) and the shared conversion units.

Parameters:
WIDTH, 4, bit width of the value to convert (>=2)
NUM_REQ, 4, number of requesters (>=2)
ID_W, $clog2(NUM_REQ), width of the response requester ID (localparam, derived)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_data  input  NUM_REQ*WIDTH  packed request values; requester i in slice [i*WIDTH +: WIDTH]
req_dir  input  NUM_REQ  per-requester direction: 0 = binary-to-Gray, 1 = Gray-to-binary
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  downstream accepts the response
rsp_data  output  WIDTH  converted value
rsp_id  output  ID_W  index of the requester that produced rsp_data

Behaviour:
- Reset (asynchronous, on rst_n low): rsp_valid=0, rsp_data=0, rsp_id=0, round-robin pointer last_grant=NUM_REQ-1 (so requester 0 has top priority first). req_ready is combinational and is therefore 0 while rsp_valid=0 and no req_valid is set.
- Response slot FSM has two states:
  - EMPTY (rsp_valid=0): any grant moves it to FULL.
  - FULL (rsp_valid=1): on rsp_ready=1 it moves to EMPTY if there is no grant this cycle, and stays FULL with new contents if there is a grant (back-to-back, no bubble).
- slot_free = !rsp_valid || rsp_ready.
- Arbitration: when slot_free=1, grant the first requester with req_valid=1, searching cyclically from last_grant+1. At most one grant per cycle.
  - req_ready[i] = grant[i]. This is combinational from req_valid and rsp_ready; requesters must not make req_valid depend on req_ready.
  - last_grant updates to the granted index only on a grant. With no requests, the pointer holds.
- Handshake: a transfer occurs on req_valid[i] & req_ready[i]. The requester holds req_data/req_dir stable until it is accepted. Dropping req_valid before acceptance is permitted and loses nothing.
- Datapath:
  - Select the granted req_data and req_dir.
  - Compute both conversions combinationally; the selected direction picks the result.
  - Register the result into rsp_data with rsp_id=index.
  - Latency: accepted at edge N, rsp_valid=1 with result after edge N; throughput is 1 per cycle with rsp_ready held high.
- Stall (rsp_valid=1, rsp_ready=0): rsp_data and rsp_id hold stable, all req_ready=0, and the pointer is frozen.
- Simultaneous drain and accept: the old response is consumed and the new one is loaded on the same edge.
- Index wrap: after a grant to NUM_REQ-1, the search starts at 0.
- Reset mid-operation: any in-flight response is discarded and not replayed. The pointer returns to NUM_REQ-1.
- Width rules: conversion is purely bitwise over WIDTH bits, with no sign extension or truncation.

Optional Feature:
- Macro: GRAY_CONV_ARB_STATS_EN.
- When defined:
  - Adds output port stall_cnt (16 bits): a saturating count of cycles with rsp_valid=1 & rsp_ready=0. Reset value is 0; it holds at 16'hFFFF once saturated.
  - Adds input port stall_clr (1 bit): synchronously clears the counter. If stall_clr and a stall occur in the same cycle, the clear wins and the counter reads 0.
- When undefined: neither port nor the counter logic exists. Functional behaviour is identical.

Decomposition:
- Package gray_conv_pkg:
  - typedef enum logic {DIR_B2G=1'b0, DIR_G2B=1'b1} conv_dir_e
  - typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e
  - localparam STAT_W=16
- Sub-module rr_arbiter (NUM_REQ parameter):
  - inputs: clk, rst_n, req vector, enable (slot_free)
  - outputs: one-hot grant and grant index
  - owns last_grant
- The top level instantiates rr_arbiter, Binary2Gray and Gray2Binary (WIDTH passed through) plus the response register.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> rsp_valid=0, rsp_data=0, rsp_id=0; first grant after release goes to req 0.
- Single binary-to-Gray: req0 data=4'b1011 dir=0, rsp_ready=1 -> req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_data=4'b1110, rsp_id=0.
- Single Gray-to-binary: req2 data=4'b1110 dir=1 -> next cycle rsp_data=4'b1011, rsp_id=2. Sweep 0..15 in both directions; a round trip must return the original value.
- Fairness: all four req_valid held high, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: rsp_valid=1 with rsp_data=4'b0110, then rsp_ready=0 for 3 cycles -> rsp_data and rsp_id stable, req_ready=0. With GRAY_CONV_ARB_STATS_EN defined, stall_cnt=3; stall_clr pulsed in a stall cycle -> stall_cnt=0.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 and req1 is pending -> rsp_valid drops immediately without waiting for clk. After release the response is not replayed, and a grant goes to req 0 if it is valid.
